// File: rtl/timing_step_seq.sv
// -----------------------------------------------------------------------------
// timing_step_seq
//
// Sequence-counter stage of the hardwired control unit. Produces the 4-bit
// control-step code that feeds the downstream 4-to-16 step decoder
// (sc[3] -> decoder input a ... sc[0] -> input d, so decoder out[n] = Tn).
// Handles run/idle/halt control, end-of-instruction clear, single-step mode
// and halting at instruction boundaries.
//
// Parameters:
//   MAX_STEP  last step index (0..15); sc returns to 0 after this value
//   CNT_W     width of cycle_cnt
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       pulse: leave IDLE or HALT, begin at T0
//   halt_req    pulse: halt at the next instruction boundary
//   clr_sc      end-of-instruction from control logic (next sc = 0)
//   step_mode   1 = sc advances only on step_go
//   step_go     single-step advance pulse (ignored when step_mode = 0)
//   sc          current step code
//   sc_valid    sc is a live timing step (state RUN)
//   running     state == RUN
//   halted      state == HALT
//   instr_done  one-cycle pulse on the first sc = 0 cycle after a boundary
//   halt_pend   halt request latched, not yet taken
//   cycle_cnt   count of RUN cycles that advanced the sequence
//
// Build option:
//   TIMING_SEQ_CYCLE_CNT_EN  when defined, cycle_cnt is a live counter that
//   is cleared by start; when undefined, cycle_cnt is tied to zero.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module timing_step_seq #(
  parameter int unsigned MAX_STEP = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             clr_sc,
  input  logic             step_mode,
  input  logic             step_go,
  output logic [3:0]       sc,
  output logic             sc_valid,
  output logic             running,
  output logic             halted,
  output logic             instr_done,
  output logic             halt_pend,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_STEP = 4'(MAX_STEP);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_sc;
  logic [3:0] w_sc_nxt;
  logic       r_instr_done;
  logic       w_instr_done_nxt;
  logic       r_halt_pend;
  logic       w_halt_pend_nxt;
  logic       r_running;
  logic       r_halted;

  // Advance qualifier: free-running, or one step per step_go in step mode.
  logic w_adv;
  // Instruction boundary: only evaluated on a cycle that actually advances,
  // so a clr_sc without an advance is simply not seen.
  logic w_bnd;
  // A boundary that also carries a halt (latched or arriving this cycle).
  logic w_take_halt;

  assign w_adv       = ~step_mode | step_go;
  assign w_bnd       = w_adv & (clr_sc | (r_sc == LP_MAX_STEP));
  assign w_take_halt = w_bnd & (r_halt_pend | halt_req);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the async reset clears every flop, so a reset mid-instruction drops
  // sc and any pending halt at once without emitting instr_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start)       w_state_nxt = ST_RUN;
      ST_RUN:  if (w_take_halt) w_state_nxt = ST_HALT;
      ST_HALT: if (start)       w_state_nxt = ST_RUN;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sc_nxt         = r_sc;
    w_instr_done_nxt = 1'b0;
    w_halt_pend_nxt  = r_halt_pend;
    unique case (r_state)
      ST_IDLE: begin
        // halt_req is ignored while idle; the first RUN cycle shows T0.
        w_sc_nxt        = 4'd0;
        w_halt_pend_nxt = 1'b0;
      end
      ST_RUN: begin
        if (w_adv) begin
          if (w_bnd) begin
            // Both boundary variants restart at T0 and flag the boundary.
            // Any halt pending here is taken now, so pend always clears.
            w_sc_nxt         = 4'd0;
            w_instr_done_nxt = 1'b1;
            w_halt_pend_nxt  = 1'b0;
          end else begin
            w_sc_nxt        = r_sc + 4'd1;
            w_halt_pend_nxt = r_halt_pend | halt_req;
          end
        end else begin
          // Stalled step: sc holds, but a halt request is still remembered.
          w_halt_pend_nxt = r_halt_pend | halt_req;
        end
      end
      ST_HALT: begin
        w_sc_nxt = 4'd0;
        // A halt_req arriving with start is kept for the next boundary.
        w_halt_pend_nxt = start & halt_req;
      end
      default: begin
        w_sc_nxt        = 4'd0;
        w_halt_pend_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc         <= 4'd0;
      r_instr_done <= 1'b0;
      r_halt_pend  <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_sc         <= w_sc_nxt;
      r_instr_done <= w_instr_done_nxt;
      r_halt_pend  <= w_halt_pend_nxt;
      r_running    <= (w_state_nxt == ST_RUN);
      r_halted     <= (w_state_nxt == ST_HALT);
    end
  end

  assign sc         = r_sc;
  assign sc_valid   = r_running;
  assign running    = r_running;
  assign halted     = r_halted;
  assign instr_done = r_instr_done;
  assign halt_pend  = r_halt_pend;

  // ---------------------------------------------------------------------------
  // Advance counter
  // ---------------------------------------------------------------------------
`ifdef TIMING_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

  // start only has effect outside RUN, so only then does it clear the count.
  assign w_cnt_clr = start & (r_state != ST_RUN);
  assign w_cnt_inc = (r_state == ST_RUN) & w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: doc/timing_step_seq.md
Name: timing_step_seq

Overview:
- Sequence-counter stage for the hardwired control unit.
- Generates the 4-bit control-step code that drives the 4-to-16 step decoder directly downstream. sc[3] feeds decoder input a and sc[0] feeds input d, so decoder out[n] is timing signal Tn.
- Handles run/idle/halt control, end-of-instruction clear, single-step mode and instruction-boundary halting.

Parameters:
- MAX_STEP, 15, last step index (0..15); sc wraps to 0 after this value.
- CNT_W, 16, width of cycle_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves IDLE or HALT, begins at T0
- halt_req  in  1  pulse; request halt at the next instruction boundary
- clr_sc  in  1  end-of-instruction from control logic; next sc = 0
- step_mode  in  1  1 = sc advances only on step_go
- step_go  in  1  single-step advance pulse; ignored when step_mode=0
- sc  out  4  current step code, feeds decoder {a,b,c,d}
- sc_valid  out  1  1 when sc is a live timing step (state RUN)
- running  out  1  state == RUN
- halted  out  1  state == HALT
- instr_done  out  1  one-cycle pulse, coincident with the first cycle of sc=0 after a boundary
- halt_pend  out  1  halt request latched, not yet taken
- cycle_cnt  out  CNT_W  advance count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; sc=0.
  - sc_valid, running, halted, instr_done, halt_pend, cycle_cnt all 0.
  - Reset mid-instruction discards sc and any pending halt immediately; no instr_done is produced.
- All outputs are registered.
- States: IDLE, RUN, HALT.
- IDLE:
  - sc=0, sc_valid=0.
  - start=1 -> RUN next cycle with sc=0, sc_valid=1.
  - halt_req in IDLE is ignored.
- RUN, advance condition: adv = (step_mode==0) | step_go. Without adv, sc holds and clr_sc/halt boundary evaluation waits.
- RUN, boundary condition: bnd = adv & (clr_sc | sc==MAX_STEP).
- RUN, priority on each cycle with adv (highest first):
  1. bnd & (halt_pend | halt_req) -> HALT; sc=0; instr_done=1 for one cycle; halt_pend cleared.
  2. bnd -> sc=0; instr_done=1.
  3. otherwise sc=sc+1.
- halt_req in RUN without bnd sets halt_pend (sticky) until taken.
- halt_req and bnd in the same cycle take the halt in that cycle.
- clr_sc with adv=0 is not latched; control must hold clr_sc until the step advances.
- start in RUN is ignored.
- HALT:
  - sc=0, sc_valid=0, halted=1.
  - start -> RUN with sc=0.
  - start and halt_req together in HALT -> RUN, with halt_pend set.
- Latency: one cycle from a sampled input to the registered sc/state change.
- MAX_STEP=15 wraps naturally. Smaller values force the wrap at MAX_STEP; sc never exceeds MAX_STEP.
- step_mode may change at any time and takes effect on the same cycle's adv evaluation.

Optional Feature:
- Macro: TIMING_SEQ_CYCLE_CNT_EN.
- Defined:
  - cycle_cnt increments by 1 on every RUN cycle with adv=1, including boundary cycles.
  - Wraps modulo 2^CNT_W.
  - Cleared by reset and by start when leaving IDLE or HALT.
- Undefined: cycle_cnt is tied to 0 and no counter flops are inferred. The port exists in both builds.

Test Plan:
- Reset, then start pulse, step_mode=0, MAX_STEP=15 -> sc = 0,1,...,15,0 on successive cycles; instr_done high only on the cycle sc returns to 0; sc_valid=1 throughout.
- RUN, clr_sc=1 while sc=3 -> next sc=0 with instr_done=1; no values 4..15 appear.
- halt_req pulse at sc=5, clr_sc at sc=7 -> halt_pend=1 from sc=6; after sc=7: halted=1, sc=0, instr_done=1, halt_pend=0. Then start -> sc=0, running=1.
- step_mode=1, step_go pulsed every 3rd cycle -> sc holds between pulses. clr_sc held at sc=2 without step_go -> no clear until the next step_go.
- MAX_STEP=5 -> sequence 0..5,0. rst_n asserted at sc=3 -> sc=0 and IDLE immediately (asynchronously); no instr_done.
- With TIMING_SEQ_CYCLE_CNT_EN, 20 advances after start -> cycle_cnt=20. Without the macro -> cycle_cnt=0 throughout.
